serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

- Framed serial receiver for the bit stream that the shift register's `o_Sout` produces in parallel-to-serial mode.
- Samples one bit per bit-strobe and detects the start bit.
- Assembles `BW_DATA` data bits MSB-first, checks even parity and the stop bit, then presents the word in a holding register with a valid/ready handshake.
- Sits directly downstream of the shift register and turns its serial output back into parallel words with error status.

## Interface
Parameters:
- `BW_DATA`, 8, data bits per frame
- `BW_CNT`, 8, width of the saturating error counter
- `PARITY_EN`, 1, 1 = the frame carries an even-parity bit; 0 = no parity bit, `o_ParErr` is always 0

Ports (one clock; reset is asynchronous and active-high):
- `i_Clk`  in  1  clock, rising edge
- `i_Rst`  in  1  asynchronous reset, active-high
- `i_BitEn`  in  1  bit strobe; `i_Sin` is sampled only on edges where this is 1
- `i_Sin`  in  1  serial line, idles high
- `i_Ready`  in  1  consumer accepts the word in the holding register
- `o_Data`  out  `BW_DATA`  received word
- `o_Valid`  out  1  holding register full
- `o_ParErr`  out  1  parity error of the held word, qualified by `o_Valid`
- `o_FrmErr`  out  1  stop-bit error of the held word, qualified by `o_Valid`
- `o_Overrun`  out  1  one-cycle pulse: a completed frame was dropped
- `o_Busy`  out  1  a frame is in progress (state other than IDLE)
- `o_ErrCnt`  out  `BW_CNT`  count of parity plus frame errors, saturating at all-ones

## Operation
Frame on the line:
- 1 start bit (0), then `BW_DATA` data bits MSB first, then the parity bit if `PARITY_EN`, then 1 stop bit (1).

FSM states and transitions (all advance only on `i_BitEn`=1 samples):
- IDLE: sample 0 → DATA (bit counter = 0); sample 1 → stay.
- DATA: shift the sample in; after `BW_DATA` samples → PARITY if `PARITY_EN`, else STOP.
- PARITY: store the bit; parity error = XOR of the data bits and the parity bit is 1.
- STOP: sample 1 → IDLE; sample 0 → frame error, go to WAIT_HI.
- WAIT_HI: stay until a sample of 1, then → IDLE. A low line (break) never produces repeated frames.

Holding register and handshake:
- The frame completes on the stop sample, whether the frame is good or bad.
- Errored words are still delivered, with their flags set.
- A word moves from holding to consumer on any edge where `o_Valid`=1 and `i_Ready`=1.
- Completion while the holding register is empty or being consumed in the same cycle: load data and flags, `o_Valid`=1. There is no overrun in the simultaneous-consume case.
- Completion while `o_Valid`=1 and `i_Ready`=0: drop the new word and hold the old word and flags unchanged. `o_Overrun`=1 for one cycle, but `o_ErrCnt` still counts the dropped word's errors.
- `o_ErrCnt` adds 1 for a parity error and 1 for a frame error (up to +2 per frame), saturating.

Reset:
- All outputs go to 0 and the FSM to IDLE.
- Reset mid-frame discards the partial frame; the holding register is cleared.

## Timing
- Bits 0 and 1 of `i_Sin` at a sampled edge are taken at that rising edge.
- `o_Valid`, `o_Data`, `o_ParErr` and `o_FrmErr` update at the same edge that samples the stop bit: visible the cycle after the stop bit is presented.
- `o_Overrun` is high for exactly the one cycle following that edge.
- `o_Valid` falls the cycle after an edge with `i_Ready`=1, unless a new word loads on the same edge.
- `o_Busy` rises after the start-bit sample and falls after the edge that returns the FSM to IDLE.
- `i_BitEn`=0 freezes the FSM, bit counter and shifter; the handshake still operates.

## Structure
- Shared package `serial_frame_pkg`: FSM state encodings (IDLE, DATA, PARITY, STOP, WAIT_HI), default `BW_DATA`, start/stop/idle bit-level constants.
- The package is reused by the future matching transmitter.
- One sub-module, `rx_hold_reg`: the holding register with valid/ready handshake, overrun detection and error flags.
- Top level contains the FSM, bit counter, data shifter, parity accumulator and error counter.

## Test plan
- Good frame, `i_BitEn`=1 every cycle: line 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1), `i_Ready`=1 → `o_Data`=0xA5 and `o_Valid`=1 for one cycle after the stop sample; `o_ParErr`=0, `o_FrmErr`=0, `o_ErrCnt`=0.
- Parity error: 0x3C with parity bit 1 → `o_Data`=0x3C, `o_ParErr`=1, `o_ErrCnt`=1.
- Frame error then break: 0x0F, parity 0, stop 0, line held low 5 samples, then high → `o_FrmErr`=1; no further `o_Valid` until a high sample followed by a new start bit.
- Overrun: 0x11 then 0x22 with `i_Ready`=0 → `o_Data` stays 0x11, `o_Overrun` pulses once at the 0x22 stop edge. Repeat with `i_Ready`=1 on that edge → `o_Data`=0x22, no overrun.
- Strobe gating: `i_BitEn` high every 4th cycle, frame 0xC3 with `i_Sin` held for 4 cycles per bit → `o_Data`=0xC3; state is unchanged on non-strobe cycles.
- Reset mid-frame: assert `i_Rst` after 4 data bits of 0xFF → all outputs 0 and `o_Busy`=0; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver and the matching transmitter.
package serial_frame_pkg;

    localparam int BW_DATA_DEF = 8;

    // Bit-level line constants
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_PARITY  = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } rx_state_t;

    // Error status travelling with a received word
    typedef struct packed {
        logic par_err;
        logic frm_err;
    } rx_flags_t;

endpackage

// File: rtl/serial_frame_rx_hold_reg.sv
// Holding register between the frame decoder and the consumer.
// A completed frame loads when the register is empty or drains on the same
// edge; otherwise the new word is dropped and overrun pulses for one cycle.
module rx_hold_reg
    import serial_frame_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Load,
    input  logic [BW_DATA-1:0] i_Data,
    input  rx_flags_t          i_Flags,
    input  logic               i_Ready,
    output logic [BW_DATA-1:0] o_Data,
    output logic               o_Valid,
    output rx_flags_t          o_Flags,
    output logic               o_Overrun
);

    logic accept;
    assign accept = !o_Valid || i_Ready;

    // Load / drain / overrun handling
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Data    <= '0;
            o_Valid   <= 1'b0;
            o_Flags   <= '0;
            o_Overrun <= 1'b0;
        end else begin
            o_Overrun <= 1'b0;
            if (i_Load) begin
                if (accept) begin
                    o_Data  <= i_Data;
                    o_Flags <= i_Flags;
                    o_Valid <= 1'b1;
                end else begin
                    o_Overrun <= 1'b1;
                end
            end else if (o_Valid && i_Ready) begin
                o_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, BW_DATA bits MSB first, optional even
// parity, stop bit. Words are handed to rx_hold_reg with their error flags.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int BW_DATA   = BW_DATA_DEF,
    parameter int BW_CNT    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_BitEn,
    input  logic               i_Sin,
    input  logic               i_Ready,
    output logic [BW_DATA-1:0] o_Data,
    output logic               o_Valid,
    output logic               o_ParErr,
    output logic               o_FrmErr,
    output logic               o_Overrun,
    output logic               o_Busy,
    output logic [BW_CNT-1:0]  o_ErrCnt
);

    localparam int CNT_W = $clog2(BW_DATA + 1);

    rx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BW_DATA-1:0] shreg;
    logic               par_acc;
    logic               par_err_q;

    logic               done;
    rx_flags_t          done_flags;
    rx_flags_t          hold_flags;
    logic [1:0]         err_inc;
    logic [BW_CNT:0]    err_sum;
    logic [BW_CNT-1:0]  err_cnt;

    // The frame completes on the stop sample regardless of its value
    assign done               = i_BitEn && (state == ST_STOP);
    assign done_flags.par_err = (PARITY_EN != 0) && par_err_q;
    assign done_flags.frm_err = (i_Sin != STOP_BIT);

    // Frame decoder: advances only on strobed samples
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
        end else if (i_BitEn) begin
            case (state)
                ST_IDLE: begin
                    if (i_Sin == START_BIT) begin
                        state     <= ST_DATA;
                        bit_cnt   <= '0;
                        par_acc   <= 1'b0;
                        par_err_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    shreg   <= {shreg[BW_DATA-2:0], i_Sin};
                    par_acc <= par_acc ^ i_Sin;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BW_DATA - 1))
                        state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    par_err_q <= par_acc ^ i_Sin;
                    state     <= ST_STOP;
                end
                ST_STOP: begin
                    state <= (i_Sin == STOP_BIT) ? ST_IDLE : ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    // A held-low line must not be decoded as a string of frames
                    if (i_Sin == IDLE_BIT)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign err_inc = 2'(done_flags.par_err) + 2'(done_flags.frm_err);
    assign err_sum = {1'b0, err_cnt} + {{(BW_CNT-1){1'b0}}, err_inc};

    // Saturating error counter; dropped words still count
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            err_cnt <= '0;
        else if (done)
            err_cnt <= err_sum[BW_CNT] ? {BW_CNT{1'b1}} : err_sum[BW_CNT-1:0];
    end

    rx_hold_reg #(
        .BW_DATA (BW_DATA)
    ) u_hold (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Load    (done),
        .i_Data    (shreg),
        .i_Flags   (done_flags),
        .i_Ready   (i_Ready),
        .o_Data    (o_Data),
        .o_Valid   (o_Valid),
        .o_Flags   (hold_flags),
        .o_Overrun (o_Overrun)
    );

    assign o_ParErr = hold_flags.par_err;
    assign o_FrmErr = hold_flags.frm_err;
    assign o_Busy   = (state != ST_IDLE);
    assign o_ErrCnt = err_cnt;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame-level reference model checked every cycle,
// plus literal expectations at the end of each directed frame.
module tb_serial_frame_rx;

    localparam int BW = 8;
    localparam int PE = 1;
    localparam int FL = BW + PE + 1;   // bits after the start bit

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_en = 1'b0;
    logic          sin = 1'b1;
    logic          ready = 1'b0;
    logic [BW-1:0] o_data;
    logic          o_valid, o_par, o_frm, o_ovr, o_busy;
    logic [7:0]    o_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_frame_rx #(.BW_DATA(BW), .BW_CNT(8), .PARITY_EN(PE)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_BitEn(bit_en), .i_Sin(sin), .i_Ready(ready),
        .o_Data(o_data), .o_Valid(o_valid), .o_ParErr(o_par), .o_FrmErr(o_frm),
        .o_Overrun(o_ovr), .o_Busy(o_busy), .o_ErrCnt(o_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int       mode;            // 0 idle, 1 collecting, 2 waiting for line high
    logic     q[$];
    logic [BW-1:0] m_data;
    logic     m_valid, m_par, m_frm, m_ovr, m_busy;
    int       m_cnt;

    always @(posedge clk) begin
        logic done, pe, fe;
        logic [BW-1:0] d;
        if (rst) begin
            mode = 0; q.delete();
            m_data = '0; m_valid = 0; m_par = 0; m_frm = 0; m_ovr = 0; m_busy = 0; m_cnt = 0;
        end else begin
            done = 0; pe = 0; fe = 0; d = '0;
            if (bit_en) begin
                case (mode)
                    0: if (!sin) begin mode = 1; q.delete(); end
                    1: begin
                        q.push_back(sin);
                        if (q.size() == FL) begin
                            for (int i = 0; i < BW; i++) d = (d << 1) | BW'(q[i]);
                            pe = (PE != 0) ? 1'(($countones(d) + int'(q[BW])) % 2) : 1'b0;
                            fe = !q[FL-1];
                            done = 1;
                            mode = fe ? 2 : 0;
                        end
                    end
                    default: if (sin) mode = 0;
                endcase
            end
            m_ovr = 0;
            if (done) begin
                if (!m_valid || ready) begin
                    m_data = d; m_par = pe; m_frm = fe; m_valid = 1;
                end else m_ovr = 1;
                m_cnt = m_cnt + int'(pe) + int'(fe);
                if (m_cnt > 255) m_cnt = 255;
            end else if (m_valid && ready) m_valid = 0;
            m_busy = (mode != 0);
        end
    end

    // Per-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("data",    32'(o_data),  32'(m_data));
            chk("valid",   32'(o_valid), 32'(m_valid));
            chk("parerr",  32'(o_par),   32'(m_par));
            chk("frmerr",  32'(o_frm),   32'(m_frm));
            chk("overrun", 32'(o_ovr),   32'(m_ovr));
            chk("busy",    32'(o_busy),  32'(m_busy));
            chk("errcnt",  32'(o_cnt),   32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b, input int period);
        for (int k = 0; k < period; k++) begin
            @(posedge clk); #2;
            sin = b;
            bit_en = (k == period - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; sin = 1'b1; bit_en = 1'b1; end
    endtask

    // Returns just after the edge that samples the stop bit
    task automatic send_frame(input logic [BW-1:0] d, input logic pbit, input logic stop,
                              input int period, input logic rdy_stop);
        send_bit(1'b0, period);
        for (int i = BW - 1; i >= 0; i--) send_bit(d[i], period);
        if (PE != 0) send_bit(pbit, period);
        ready = rdy_stop;
        send_bit(stop, period);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data",  32'(o_data),  32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_busy",  32'(o_busy),  32'h0);
        chk("rst_cnt",   32'(o_cnt),   32'h0);
        rst = 1'b0;
        ready = 1'b1;
        idle(3);

        // Good frame
        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1);
        chk("t1_data",  32'(o_data),  32'hA5);
        chk("t1_valid", 32'(o_valid), 32'h1);
        chk("t1_par",   32'(o_par),   32'h0);
        chk("t1_frm",   32'(o_frm),   32'h0);
        chk("t1_cnt",   32'(o_cnt),   32'h0);
        idle(1);
        chk("t1_vfall", 32'(o_valid), 32'h0);
        idle(2);

        // Parity error
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1);
        chk("t2_data", 32'(o_data), 32'h3C);
        chk("t2_par",  32'(o_par),  32'h1);
        chk("t2_cnt",  32'(o_cnt),  32'h1);
        idle(2);

        // Frame error followed by a break
        send_frame(8'h0F, 1'b0, 1'b0, 1, 1'b1);
        chk("t3_frm",   32'(o_frm),   32'h1);
        chk("t3_valid", 32'(o_valid), 32'h1);
        chk("t3_cnt",   32'(o_cnt),   32'h2);
        repeat (5) send_bit(1'b0, 1);
        chk("t3_brkbusy", 32'(o_busy), 32'h1);
        idle(3);
        chk("t3_novalid", 32'(o_valid), 32'h0);
        chk("t3_idle",    32'(o_busy),  32'h0);

        // Overrun: consumer stalled
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0);
        chk("t4_hold", 32'(o_data), 32'h11);
        chk("t4_ovr",  32'(o_ovr),  32'h1);
        idle(1);
        chk("t4_ovr1", 32'(o_ovr),  32'h0);
        ready = 1'b1;
        idle(2);
        // Same, but consumer drains on the completing edge
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b1);
        chk("t4b_data",  32'(o_data),  32'h22);
        chk("t4b_ovr",   32'(o_ovr),   32'h0);
        chk("t4b_valid", 32'(o_valid), 32'h1);
        chk("t4b_cnt",   32'(o_cnt),   32'h2);
        idle(2);

        // Strobe every 4th cycle
        send_frame(8'hC3, 1'b0, 1'b1, 4, 1'b1);
        chk("t5_data",  32'(o_data),  32'hC3);
        chk("t5_valid", 32'(o_valid), 32'h1);
        idle(3);

        // Reset mid-frame
        send_bit(1'b0, 1);
        repeat (4) send_bit(1'b1, 1);
        @(posedge clk); #2;
        chk("t6_busy_pre", 32'(o_busy), 32'h1);
        rst = 1'b1; bit_en = 1'b0;
        #2;
        chk("t6_busy",  32'(o_busy),  32'h0);
        chk("t6_valid", 32'(o_valid), 32'h0);
        chk("t6_data",  32'(o_data),  32'h0);
        chk("t6_cnt",   32'(o_cnt),   32'h0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        idle(2);
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b1);
        chk("t6_next",  32'(o_data),  32'h5A);
        chk("t6_nval",  32'(o_valid), 32'h1);
        chk("t6_npar",  32'(o_par),   32'h0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
